dm_responder: RTL and testbench

Data-memory responder for the pipelined MIPS core's load/store port, replacing the single-cycle DM with a valid/ready request–response target. The core's M stage issues one request at a time; this block accepts it, optionally holds it for programmable wait states, commits writes with byte enables, and returns read data with an error flag. The core stalls on `req_ready` low or on a missing `rsp_valid`.

---
 rtl/dm_responder.sv | 206 ++++++++++++++++++++
 tb/tb_dm_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: valid/ready load/store target with byte enables.
// Optional wait states compiled in with `define DM_WAIT_STATE_EN.
module dm_responder #(
  parameter int DEPTH_WORDS = 3072,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          in_err;
  logic [AW-1:0] in_idx;
  logic          commit;
  logic          c_we;
  logic          c_err;
  logic [AW-1:0] c_idx;
  logic [3:0]    c_be;
  logic [31:0]   c_wdata;
  logic [31:0]   c_pc;
  logic [31:0]   c_old;
  logic [31:0]   c_merged;

  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_rdata_q;

  logic unused_bits;
  assign unused_bits = ^req_addr[1:0];

  assign accept = req_valid & req_ready;
  assign in_err = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS))
                | (req_be == 4'b0000);
  assign in_idx = req_addr[AW+1:2];
  assign busy   = (state_q != S_IDLE);

`ifdef DM_WAIT_STATE_EN
  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);

  logic [3:0]    cnt_q, cnt_d;
  logic          use_lat;
  logic          l_we_q;
  logic          l_err_q;
  logic [AW-1:0] l_idx_q;
  logic [3:0]    l_be_q;
  logic [31:0]   l_wdata_q;
  logic [31:0]   l_pc_q;

  assign req_ready = (state_q != S_WAIT);

  // Next state: commit on the edge entering RESP, from inputs or latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    use_lat = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == WLAST) begin
          state_d = S_RESP;
          commit  = 1'b1;
          use_lat = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Hold the accepted request so the core may move on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= 4'd0;
      l_we_q    <= 1'b0;
      l_err_q   <= 1'b0;
      l_idx_q   <= '0;
      l_be_q    <= 4'd0;
      l_wdata_q <= 32'd0;
      l_pc_q    <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        l_we_q    <= req_we;
        l_err_q   <= in_err;
        l_idx_q   <= in_idx;
        l_be_q    <= req_be;
        l_wdata_q <= req_wdata;
        l_pc_q    <= req_pc;
      end
    end
  end

  assign c_we    = use_lat ? l_we_q    : req_we;
  assign c_err   = use_lat ? l_err_q   : in_err;
  assign c_idx   = use_lat ? l_idx_q   : in_idx;
  assign c_be    = use_lat ? l_be_q    : req_be;
  assign c_wdata = use_lat ? l_wdata_q : req_wdata;
  assign c_pc    = use_lat ? l_pc_q    : req_pc;
`else
  logic unused_wc;
  assign unused_wc = (WAIT_CYCLES > 15);

  assign req_ready = 1'b1;

  // Next state: every accept commits immediately and enters RESP.
  always_comb begin
    state_d = accept ? S_RESP : S_IDLE;
    commit  = accept;
  end

  assign c_we    = req_we;
  assign c_err   = in_err;
  assign c_idx   = in_idx;
  assign c_be    = req_be;
  assign c_wdata = req_wdata;
  assign c_pc    = req_pc;
`endif

  assign c_old = c_err ? 32'd0 : mem_q[c_idx];

  // Byte-lane merge of store data into the current word.
  always_comb begin
    c_merged = c_old;
    for (int i = 0; i < 4; i++) begin
      if (c_be[i]) c_merged[8*i +: 8] = c_wdata[8*i +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Registered response, nonzero only for the cycle spent in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      rsp_valid_q <= commit;
      rsp_err_q   <= commit & c_err;
      rsp_rdata_q <= (commit & ~c_we & ~c_err) ? c_old : 32'd0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  // Word storage; reset clears every word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'd0;
    end else if (commit & c_we & ~c_err) begin
      mem_q[c_idx] <= c_merged;
    end
  end

`ifndef SYNTHESIS
  // Store trace for comparison against the reference core.
  always_ff @(posedge clk) begin
    if (reset && commit && c_we && !c_err)
      $display("@%h: *%h <= %h", c_pc,
               {{(30-AW){1'b0}}, c_idx, 2'b00}, c_merged);
  end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: vector table, corner sequences, random vs model.
// Latency expectation follows `DM_WAIT_STATE_EN when defined.
module tb_dm_responder;

  localparam int WC    = 2;
  localparam int DEPTH = 3072;
`ifdef DM_WAIT_STATE_EN
  localparam int LAT = 1 + WC;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] req_pc = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl [DEPTH];

  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be),
    .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
  endtask

  // Memory semantics: out-of-range or empty enables are errors with no
  // effect; a load returns the old word; a store returns zero data.
  task automatic mdl_step(input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err);
    int unsigned w;
    w   = addr / 4;
    err = (w >= DEPTH) || (be == 4'd0);
    rd  = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mdl[w][8*i +: 8] = wd[8*i +: 8];
      end else begin
        rd = mdl[w];
      end
    end
  endtask

  // One isolated request; inputs are scrambled after acceptance.
  task automatic xact(input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err,
                      output int lat, output logic ok);
    int n;
    @(negedge clk);
    req_we = we; req_addr = addr; req_be = be;
    req_wdata = wd; req_pc = $urandom; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = 1'b0; rd = 32'd0; err = 1'b0; lat = 0;
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_we = $urandom; req_addr = $urandom;
    req_be = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    ok  = rsp_valid;
    rd  = rsp_rdata;
    err = rsp_err;
  endtask

  task automatic run_one(input string nm, input logic we,
                         input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        err, ok;
    int          lat;
    xact(we, addr, be, wd, rd, err, lat, ok);
    check({nm, " rsp_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      check({nm, " latency"}, lat, LAT);
      check({nm, " rdata"}, rd, exp_rd);
      check({nm, " err"}, 32'(err), 32'(exp_err));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] erd, a, wd;
    logic        eerr, we;
    logic [3:0]  be;
    int          pulses;
    logic [31:0] exp_q [$];

    vecs[0]  = '{1'b1, 32'h10,   4'b1111, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h10,   4'b1111, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,   4'b1111, 32'h11223344, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h20,   4'b0100, 32'h00AA0000, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 32'h22,   4'b1111, 32'h0, 32'h11AA3344, 1'b0};
    vecs[5]  = '{1'b0, 32'h3000, 4'b1111, 32'h0, 32'h0, 1'b1};
    vecs[6]  = '{1'b1, 32'h20,   4'b0000, 32'hFFFFFFFF, 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 32'h20,   4'b1111, 32'h0, 32'h11AA3344, 1'b0};
    vecs[8]  = '{1'b1, 32'h2FFC, 4'b0011, 32'h0000BEEF, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h2FFC, 4'b1111, 32'h0, 32'h0000BEEF, 1'b0};
    vecs[10] = '{1'b1, 32'h3000, 4'b1111, 32'h1, 32'h0, 1'b1};
    vecs[11] = '{1'b0, 32'h2FFC, 4'b0000, 32'h0, 32'h0, 1'b1};

    mdl_clear();

    repeat (3) @(negedge clk);
    check("reset ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rdata", rsp_rdata, 32'd0);
    check("reset err", 32'(rsp_err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      mdl_step(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
               erd, eerr);
      run_one($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr,
              vecs[i].be, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err);
    end

`ifdef DM_WAIT_STATE_EN
    // Wait-state timing: ready low and busy high while waiting.
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= WC + 1; k++) begin
      check($sformatf("wait ready c%0d", k), 32'(req_ready),
            32'(k == WC + 1));
      check($sformatf("wait busy c%0d", k), 32'(busy), 32'd1);
      check($sformatf("wait valid c%0d", k), 32'(rsp_valid),
            32'(k == WC + 1));
      @(negedge clk);
    end
    check("wait idle valid", 32'(rsp_valid), 32'd0);
    check("wait idle busy", 32'(busy), 32'd0);
`else
    // Store then load back-to-back to the same word.
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h40; req_be = 4'hF;
    req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    mdl_step(1'b1, 32'h40, 4'hF, 32'hCAFEF00D, erd, eerr);
    @(negedge clk);
    check("raw st valid", 32'(rsp_valid), 32'd1);
    check("raw st rdata", rsp_rdata, 32'd0);
    req_we = 1'b0; req_wdata = 32'd0;
    @(negedge clk);
    check("raw ld valid", 32'(rsp_valid), 32'd1);
    check("raw ld rdata", rsp_rdata, 32'hCAFEF00D);
    req_valid = 1'b0;
    @(negedge clk);
    check("raw idle valid", 32'(rsp_valid), 32'd0);
    check("raw idle busy", 32'(busy), 32'd0);

    // Ten loads with valid held high: one response every cycle.
    pulses = 0;
    exp_q.delete();
    for (int k = 0; k < 11; k++) begin
      if (k > 0) begin
        if (rsp_valid) pulses++;
        check($sformatf("stream rdata%0d", k - 1), rsp_rdata,
              exp_q.pop_front());
      end
      if (k < 10) begin
        req_we = 1'b0; req_be = 4'hF;
        req_addr = 32'(k * 4) + 32'h10; req_valid = 1'b1;
        mdl_step(1'b0, req_addr, 4'hF, 32'd0, erd, eerr);
        exp_q.push_back(erd);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("stream pulses", pulses, 10);
    check("stream end valid", 32'(rsp_valid), 32'd0);
`endif

    // Reset one cycle after a store is accepted.
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h80; req_be = 4'hF;
    req_wdata = 32'h12345678; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst mid ready", 32'(req_ready), 32'd1);
    check("rst mid valid", 32'(rsp_valid), 32'd0);
    check("rst mid rdata", rsp_rdata, 32'd0);
    check("rst mid busy", 32'(busy), 32'd0);
    mdl_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_one("rst load80", 1'b0, 32'h80, 4'hF, 32'd0, 32'd0, 1'b0);
    run_one("rst load10", 1'b0, 32'h10, 4'hF, 32'd0, 32'd0, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      we = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        0:       a = 32'(DEPTH - 1) * 4;
        1:       a = 32'(DEPTH + $urandom_range(0, 100)) * 4;
        2:       a = 32'hFFFFFFFC;
        default: a = 32'($urandom_range(0, 15)) * 4;
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      be = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      wd = $urandom;
      mdl_step(we, a, be, wd, erd, eerr);
      run_one($sformatf("rnd%0d", n), we, a, be, wd, erd, eerr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
